mem_request_unit: RTL and testbench
===================================

Name: mem_request_unit

Overview:
- Registered memory request unit for the pipelined datapath.
- Holds instruction-fetch and data-memory requests between the decode/ihit point and the cache hit.
- A data request is latched when a load/store retires its fetch (ihit) and dropped on dhit.
- Adds halt sequencing, configurable fetch/data overlap, a per-request wait counter and a sticky timeout error for the memory-control bench.

Parameters:
- CNT_W, 8, width of wait_cycles counter.
- TIMEOUT, 200, DREQ cycles without dhit before timeout_err sets; 0 disables.
- IFETCH_OVERLAP, 1, 1 = imemREN stays high while a data request is pending; 0 = fetch suppressed during DREQ.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  icache hit this cycle.
- dhit  in  1  dcache hit this cycle.
- dread  in  1  decoded instruction is a load (valid with ihit).
- dwrite  in  1  decoded instruction is a store (valid with ihit).
- halt  in  1  halt instruction decoded; level, sampled every cycle.
- imemREN  out  1  instruction read request.
- dmemREN  out  1  data read request.
- dmemWEN  out  1  data write request.
- busy  out  1  data request outstanding (state DREQ).
- wait_cycles  out  CNT_W  cycles elapsed in current DREQ.
- timeout_err  out  1  sticky: a data request exceeded TIMEOUT.
- proto_err  out  1  sticky: dread and dwrite both high with ihit.

Behaviour:
- State machine: IDLE, DREQ, HALTED.
- Registered state: state, rd_q, wr_q, halt_pend, wait_cycles, timeout_err, proto_err.
- nRST low (async): state=IDLE; rd_q, wr_q, halt_pend=0; wait_cycles=0; both error flags=0.
- Outputs during reset: imemREN=0, dmemREN=0, dmemWEN=0, busy=0.
- imemREN (combinational from state, nRST high):
  - 1 in IDLE.
  - In DREQ, equals IFETCH_OVERLAP.
  - 0 in HALTED.
- dmemREN = rd_q & ~dhit; dmemWEN = wr_q & ~dhit. The combinational mask means no re-request in the cycle after dhit.
- busy = (state==DREQ).
- IDLE transitions:
  - ihit & (dread|dwrite) -> DREQ; rd_q=dread, wr_q=dwrite & ~dread; wait_cycles=0. Latency: request visible the cycle after ihit.
  - ihit & dread & dwrite -> load wins (rd_q=1, wr_q=0); proto_err sets.
  - Else halt -> HALTED.
  - Else stay in IDLE.
- DREQ transitions:
  - halt high sets halt_pend.
  - No dhit: wait_cycles increments, saturating at 2^CNT_W-1.
  - When TIMEOUT!=0 and wait_cycles reaches TIMEOUT-1 without dhit, timeout_err sets on that edge and stays set until reset. The request is NOT aborted.
  - dhit: rd_q and wr_q clear, then:
    - If halt_pend or halt -> HALTED.
    - Else if IFETCH_OVERLAP & ihit & (dread|dwrite) -> back-to-back: remain DREQ, relatch rd_q/wr_q, wait_cycles=0.
    - Else -> IDLE.
  - ihit without dhit in DREQ: new load/store is ignored. The pipeline is stalled by the hazard unit and re-presents it.
- HALTED: absorbing until nRST; all requests 0, busy=0; wait_cycles and error flags hold.
- Reset asserted mid-DREQ: request drops immediately and asynchronously; no memory side effect is owed.
- ihit and dhit are ignored whenever the corresponding request is low.

Test Plan:
- Reset then idle: nRST low 2 cycles, release -> imemREN=1, dmemREN=dmemWEN=0, busy=0, wait_cycles=0.
- Load: ihit+dread at cycle 5, dhit at cycle 9 -> dmemREN high cycles 6-8, 0 in cycle 9 (masked) and after; wait_cycles=3 in cycle 9; state IDLE at cycle 10.
- Store with IFETCH_OVERLAP=0: ihit+dwrite, dhit 2 cycles later -> dmemWEN=1 and imemREN=0 while busy; imemREN returns to 1 after dhit.
- Halt during store: halt pulses while DREQ, dhit later -> dmemWEN finishes, then HALTED with imemREN=0 permanently; a further ihit+dread produces no request.
- Timeout with TIMEOUT=4: load, dhit withheld 10 cycles -> timeout_err=1 from the 4th DREQ cycle onward, dmemREN still 1; after dhit the flag stays 1 until nRST.
- Back-to-back and protocol error: dhit coincident with ihit+dread+dwrite -> stays DREQ, dmemREN=1 and dmemWEN=0 next cycle, wait_cycles=0, proto_err=1.

Source files
------------

// File: rtl/mem_request_unit.sv
// mem_request_unit: registered I/D memory request holder between ihit and dhit,
// with halt sequencing, per-request wait counter and sticky timeout/protocol flags.
`default_nettype none

module mem_request_unit #(
   parameter int CNT_W          = 8,
   parameter int TIMEOUT        = 200,
   parameter int IFETCH_OVERLAP = 1
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dread,
   input  logic             dwrite,
   input  logic             halt,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             busy,
   output logic [CNT_W-1:0] wait_cycles,
   output logic             timeout_err,
   output logic             proto_err
);

   localparam logic [1:0]       c_IDLE   = 2'd0;
   localparam logic [1:0]       c_DREQ   = 2'd1;
   localparam logic [1:0]       c_HALTED = 2'd2;
   localparam logic [CNT_W-1:0] c_WAIT_MAX = '1;
   localparam logic [31:0]      c_TO_LIM = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
   localparam logic             c_TO_EN  = (TIMEOUT != 0);
   localparam logic             c_OVL    = (IFETCH_OVERLAP != 0);

   logic [1:0]       r_state;
   logic             r_rd_q;
   logic             r_wr_q;
   logic             r_halt_pend;
   logic [CNT_W-1:0] r_wait;
   logic             r_timeout_err;
   logic             r_proto_err;

   logic w_req;
   logic w_both;
   logic w_to_hit;

   assign w_req  = ihit & (dread | dwrite);
   assign w_both = ihit & dread & dwrite;
   // Flag fires on the edge where the counter advances to TIMEOUT-1.
   assign w_to_hit = c_TO_EN & ((32'(r_wait) + 32'd1) >= c_TO_LIM);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state       <= c_IDLE;
         r_rd_q        <= 1'b0;
         r_wr_q        <= 1'b0;
         r_halt_pend   <= 1'b0;
         r_wait        <= '0;
         r_timeout_err <= 1'b0;
         r_proto_err   <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_req) begin
                  r_state <= c_DREQ;
                  r_rd_q  <= dread;
                  r_wr_q  <= dwrite & ~dread;
                  r_wait  <= '0;
                  if (w_both) r_proto_err <= 1'b1;
               end else if (halt) begin
                  r_state <= c_HALTED;
               end
            end
            c_DREQ: begin
               if (halt) r_halt_pend <= 1'b1;
               if (dhit) begin
                  r_rd_q <= 1'b0;
                  r_wr_q <= 1'b0;
                  if (r_halt_pend || halt) begin
                     r_state <= c_HALTED;
                  end else if (c_OVL && w_req) begin
                     r_rd_q <= dread;
                     r_wr_q <= dwrite & ~dread;
                     r_wait <= '0;
                     if (w_both) r_proto_err <= 1'b1;
                  end else begin
                     r_state <= c_IDLE;
                  end
               end else begin
                  if (r_wait != c_WAIT_MAX) r_wait <= r_wait + 1'b1;
                  if (w_to_hit) r_timeout_err <= 1'b1;
               end
            end
            c_HALTED: begin
               r_state <= c_HALTED;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   // Fetch is gated by nRST so nothing is requested while reset is held.
   assign imemREN     = nRST & ((r_state == c_IDLE) | ((r_state == c_DREQ) & c_OVL));
   assign dmemREN     = r_rd_q & ~dhit;
   assign dmemWEN     = r_wr_q & ~dhit;
   assign busy        = (r_state == c_DREQ);
   assign wait_cycles = r_wait;
   assign timeout_err = r_timeout_err;
   assign proto_err   = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_request_unit.sv
// Directed bench for mem_request_unit: default, no-overlap and short-timeout instances share stimulus.
`default_nettype none

module tb_mem_request_unit;

   logic CLK = 1'b0;
   logic nRST = 1'b0;
   logic ihit = 1'b0, dhit = 1'b0, dread = 1'b0, dwrite = 1'b0, halt = 1'b0;

   logic d_im, d_re, d_we, d_busy, d_to, d_pe;
   logic [7:0] d_wait;
   logic n_im, n_re, n_we, n_busy, n_to, n_pe;
   logic [7:0] n_wait;
   logic t_im, t_re, t_we, t_busy, t_to, t_pe;
   logic [2:0] t_wait;

   int n_chk = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   mem_request_unit #(.CNT_W(8), .TIMEOUT(200), .IFETCH_OVERLAP(1)) u_def (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dread(dread), .dwrite(dwrite),
      .halt(halt), .imemREN(d_im), .dmemREN(d_re), .dmemWEN(d_we), .busy(d_busy),
      .wait_cycles(d_wait), .timeout_err(d_to), .proto_err(d_pe));

   mem_request_unit #(.CNT_W(8), .TIMEOUT(200), .IFETCH_OVERLAP(0)) u_nov (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dread(dread), .dwrite(dwrite),
      .halt(halt), .imemREN(n_im), .dmemREN(n_re), .dmemWEN(n_we), .busy(n_busy),
      .wait_cycles(n_wait), .timeout_err(n_to), .proto_err(n_pe));

   mem_request_unit #(.CNT_W(3), .TIMEOUT(4), .IFETCH_OVERLAP(1)) u_to (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dread(dread), .dwrite(dwrite),
      .halt(halt), .imemREN(t_im), .dmemREN(t_re), .dmemWEN(t_we), .busy(t_busy),
      .wait_cycles(t_wait), .timeout_err(t_to), .proto_err(t_pe));

   typedef struct {
      logic [4:0] in;   // {ihit, dhit, dread, dwrite, halt}
      logic [3:0] out;  // {imemREN, dmemREN, dmemWEN, busy}
      int         wt;
      logic       pe;
   } vec_t;

   vec_t tbl[15];

   function automatic vec_t mkv(input logic [4:0] in, input logic [3:0] out, input int wt,
                                input logic pe);
      vec_t v;
      v.in = in; v.out = out; v.wt = wt; v.pe = pe;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drive inputs just after a rising edge, then move to the falling edge for sampling.
   task automatic apply(input logic [4:0] in);
      {ihit, dhit, dread, dwrite, halt} = in;
      @(negedge CLK);
   endtask

   task automatic adv();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      {ihit, dhit, dread, dwrite, halt} = 5'b0;
      @(negedge CLK);
      chk("rst imemREN", 32'(d_im), 0);
      chk("rst dmemREN", 32'(d_re), 0);
      chk("rst dmemWEN", 32'(d_we), 0);
      chk("rst busy", 32'(d_busy), 0);
      @(posedge CLK);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   initial begin
      tbl[0]  = mkv(5'b00000, 4'b1000, 0, 1'b0);
      tbl[1]  = mkv(5'b10100, 4'b1000, 0, 1'b0);
      tbl[2]  = mkv(5'b00000, 4'b1101, 0, 1'b0);
      tbl[3]  = mkv(5'b00000, 4'b1101, 1, 1'b0);
      tbl[4]  = mkv(5'b00000, 4'b1101, 2, 1'b0);
      tbl[5]  = mkv(5'b01000, 4'b1001, 3, 1'b0);
      tbl[6]  = mkv(5'b00000, 4'b1000, 3, 1'b0);
      tbl[7]  = mkv(5'b10010, 4'b1000, 3, 1'b0);
      tbl[8]  = mkv(5'b00000, 4'b1011, 0, 1'b0);
      tbl[9]  = mkv(5'b11110, 4'b1001, 1, 1'b0);
      tbl[10] = mkv(5'b00000, 4'b1101, 0, 1'b1);
      tbl[11] = mkv(5'b00001, 4'b1101, 1, 1'b1);
      tbl[12] = mkv(5'b01000, 4'b1001, 2, 1'b1);
      tbl[13] = mkv(5'b10100, 4'b0000, 2, 1'b1);
      tbl[14] = mkv(5'b00000, 4'b0000, 2, 1'b1);

      do_reset();

      // Load, store, back-to-back with protocol error, halt during request.
      for (int i = 0; i < 15; i++) begin
         apply(tbl[i].in);
         chk($sformatf("row%0d imemREN", i), 32'(d_im),   32'(tbl[i].out[3]));
         chk($sformatf("row%0d dmemREN", i), 32'(d_re),   32'(tbl[i].out[2]));
         chk($sformatf("row%0d dmemWEN", i), 32'(d_we),   32'(tbl[i].out[1]));
         chk($sformatf("row%0d busy", i),    32'(d_busy), 32'(tbl[i].out[0]));
         chk($sformatf("row%0d wait", i),    32'(d_wait), 32'(tbl[i].wt));
         chk($sformatf("row%0d proto_err", i), 32'(d_pe), 32'(tbl[i].pe));
         chk($sformatf("row%0d timeout_err", i), 32'(d_to), 0);
         adv();
      end

      // Store with fetch suppressed during the data request, then halt from idle.
      do_reset();
      apply(5'b10010);
      chk("nov idle imemREN", 32'(n_im), 1);
      chk("nov idle busy", 32'(n_busy), 0);
      adv();
      apply(5'b00000);
      chk("nov st dmemWEN", 32'(n_we), 1);
      chk("nov st imemREN", 32'(n_im), 0);
      chk("nov st busy", 32'(n_busy), 1);
      adv();
      apply(5'b01000);
      chk("nov dhit dmemWEN", 32'(n_we), 0);
      chk("nov dhit imemREN", 32'(n_im), 0);
      adv();
      apply(5'b00001);
      chk("nov after imemREN", 32'(n_im), 1);
      chk("nov after busy", 32'(n_busy), 0);
      chk("nov after dmemWEN", 32'(n_we), 0);
      adv();
      apply(5'b10100);
      chk("nov halted imemREN", 32'(n_im), 0);
      adv();
      apply(5'b00000);
      chk("nov halted dmemREN", 32'(n_re), 0);
      chk("nov halted busy", 32'(n_busy), 0);
      adv();

      // Timeout on the short-timeout instance; counter saturates at 7 with CNT_W=3.
      do_reset();
      apply(5'b10100);
      chk("to idle busy", 32'(t_busy), 0);
      adv();
      for (int k = 0; k < 10; k++) begin
         apply(5'b00000);
         chk($sformatf("to k%0d dmemREN", k), 32'(t_re), 1);
         chk($sformatf("to k%0d busy", k), 32'(t_busy), 1);
         chk($sformatf("to k%0d wait", k), 32'(t_wait), (k > 7) ? 7 : k);
         chk($sformatf("to k%0d timeout_err", k), 32'(t_to), (k >= 3) ? 1 : 0);
         chk($sformatf("def k%0d wait", k), 32'(d_wait), k);
         chk($sformatf("def k%0d timeout_err", k), 32'(d_to), 0);
         adv();
      end
      apply(5'b01000);
      chk("to dhit dmemREN", 32'(t_re), 0);
      chk("to dhit timeout_err", 32'(t_to), 1);
      adv();
      apply(5'b10100);
      chk("to idle2 busy", 32'(t_busy), 0);
      chk("to sticky timeout_err", 32'(t_to), 1);
      adv();
      apply(5'b00000);
      chk("to req2 dmemREN", 32'(t_re), 1);
      adv();

      // Asynchronous reset mid-request: request drops with no clock edge.
      #1;
      nRST = 1'b0;
      #1;
      chk("async dmemREN", 32'(t_re), 0);
      chk("async busy", 32'(t_busy), 0);
      chk("async imemREN", 32'(t_im), 0);
      chk("async timeout_err", 32'(t_to), 0);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      apply(5'b00000);
      chk("post imemREN", 32'(t_im), 1);
      chk("post wait", 32'(t_wait), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

`default_nettype wire
